// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array job sequencer.
// Skew helpers give per-lane delay depths for edge alignment.
package systolic_pkg;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACCU_W = 32;
  localparam int DEF_VEC_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_W,
    S_LOAD_WAIT,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic int left_depth(input int r);
    return r;
  endfunction

  function automatic int bot_depth(input int c, input int cols);
    return cols - 1 - c;
  endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// Fixed-depth delay line for one edge lane (data plus valid).
// Depth 0 is a plain wire.
module systolic_skew_line #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end else begin : g_reg
    logic [DEPTH-1:0] v_q;
    logic [WIDTH-1:0] d_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
      end else begin
        v_q[0] <= valid_i;
        d_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
          v_q[i] <= v_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end

    assign valid_o = v_q[DEPTH-1];
    assign data_o  = d_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer: clear, weight load, skewed activation feed and
// de-skewed result collection for a weight-stationary systolic array.
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int ROWS            = DEF_ROWS,
  parameter int COLS            = DEF_COLS,
  parameter int DATA_WIDTH      = DEF_DATA_W,
  parameter int ACCU_DATA_WIDTH = DEF_ACCU_W,
  parameter int VEC_W           = DEF_VEC_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic [VEC_W-1:0]                i_num_vec,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_w_ren,
  output logic [$clog2(ROWS)-1:0]         o_w_addr,
  input  logic [COLS*DATA_WIDTH-1:0]      i_w_rdata,
  output logic                            o_a_ren,
  output logic [VEC_W-1:0]                o_a_addr,
  input  logic [ROWS*DATA_WIDTH-1:0]      i_a_rdata,
  output logic                            o_array_rst_n,
  output logic [COLS*ACCU_DATA_WIDTH-1:0] o_top_data,
  output logic [COLS-1:0]                 o_top_valid,
  output logic [COLS-1:0]                 o_top_cmd,
  output logic [ROWS*DATA_WIDTH-1:0]      o_left_data,
  output logic [ROWS-1:0]                 o_left_valid,
  output logic [ROWS-1:0]                 o_left_cmd,
  input  logic [COLS*ACCU_DATA_WIDTH-1:0] i_bot_data,
  input  logic [COLS-1:0]                 i_bot_valid,
  output logic                            o_res_valid,
  output logic [VEC_W-1:0]                o_res_addr,
  output logic [COLS*ACCU_DATA_WIDTH-1:0] o_res_data
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACCU_DATA_WIDTH;
  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_e state_q, state_d;
  logic [RW-1:0]    ld_q, ld_d;
  logic [VEC_W-1:0] nvec_q, nvec_d;
  logic [VEC_W-1:0] iss_q, iss_d;
  logic [VEC_W-1:0] rcnt_q, rcnt_d;

  logic             w_v_q;
  logic             top_v_q;
  logic [COLS*AW-1:0] top_d_q;
  logic             a_v_q;

  logic             res_v_q;
  logic [VEC_W-1:0] res_a_q;
  logic [COLS*AW-1:0] res_d_q;

  logic [COLS-1:0]    bv;
  logic [COLS*AW-1:0] bd;
  logic               res_fire;
  logic               collect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ld_q    <= '0;
      nvec_q  <= '0;
      iss_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      nvec_q  <= nvec_d;
      iss_q   <= iss_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    nvec_d  = nvec_q;
    iss_d   = iss_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          nvec_d  = i_num_vec;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        ld_d    = '0;
        iss_d   = '0;
        state_d = S_LOAD_W;
      end
      S_LOAD_W: begin
        ld_d = ld_q + 1'b1;
        if (ld_q == LAST_ROW) begin
          ld_d    = '0;
          state_d = S_LOAD_WAIT;
        end
      end
      // Lets the last weight beat ripple down to the bottom row.
      S_LOAD_WAIT: begin
        ld_d = ld_q + 1'b1;
        if (ld_q == LAST_ROW) begin
          ld_d    = '0;
          iss_d   = '0;
          state_d = (nvec_q == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        iss_d = iss_q + 1'b1;
        if (iss_q == nvec_q - VEC_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rcnt_q == nvec_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A lone column valid without its partners never forms a row.
  assign collect  = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign res_fire = collect && (&bv);

  always_comb begin
    rcnt_d = rcnt_q + VEC_W'(res_fire);
    if (state_q == S_CLEAR) rcnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_v_q   <= 1'b0;
      top_v_q <= 1'b0;
      top_d_q <= '0;
      a_v_q   <= 1'b0;
    end else begin
      w_v_q   <= (state_q == S_LOAD_W);
      top_v_q <= w_v_q;
      a_v_q   <= (state_q == S_FEED);
      for (int c = 0; c < COLS; c++) begin
        top_d_q[c*AW +: AW] <= w_v_q ? AW'(i_w_rdata[c*DW +: DW]) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_v_q <= 1'b0;
      res_a_q <= '0;
      res_d_q <= '0;
    end else begin
      res_v_q <= res_fire;
      if (res_fire) begin
        res_a_q <= rcnt_q;
        res_d_q <= bd;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_left
    logic [DW-1:0] lane;
    assign lane = a_v_q ? i_a_rdata[r*DW +: DW] : '0;
    systolic_skew_line #(
      .DEPTH(left_depth(r)),
      .WIDTH(DW)
    ) u_skew (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid_i(a_v_q),
      .data_i (lane),
      .valid_o(o_left_valid[r]),
      .data_o (o_left_data[r*DW +: DW])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bot
    systolic_skew_line #(
      .DEPTH(bot_depth(c, COLS)),
      .WIDTH(AW)
    ) u_deskew (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid_i(i_bot_valid[c]),
      .data_i (i_bot_data[c*AW +: AW]),
      .valid_o(bv[c]),
      .data_o (bd[c*AW +: AW])
    );
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_w_ren       = (state_q == S_LOAD_W);
  assign o_w_addr      = ld_q;
  assign o_a_ren       = (state_q == S_FEED);
  assign o_a_addr      = iss_q;
  assign o_array_rst_n = rst_n & (state_q != S_CLEAR);
  assign o_top_data    = top_d_q;
  assign o_top_valid   = {COLS{top_v_q}};
  assign o_top_cmd     = {COLS{top_v_q}};
  assign o_left_cmd    = o_left_valid;
  assign o_res_valid   = res_v_q;
  assign o_res_addr    = res_a_q;
  assign o_res_data    = res_d_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: 4x4 array model, SRAM models,
// table of jobs with hand-computed results plus reset corner cases.
module tb_systolic_array_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic        busy, done, w_ren, a_ren, arr_rst_n;
  logic [1:0]  w_addr;
  logic [15:0] a_addr;
  logic [31:0] w_rdata = '0;
  logic [31:0] a_rdata = '0;
  logic [63:0] top_data, bot_data, res_data;
  logic [3:0]  top_valid, top_cmd, left_valid, left_cmd, bot_valid;
  logic [31:0] left_data;
  logic        res_valid;
  logic [15:0] res_addr;
  logic [3:0]  force_v = '0;

  systolic_array_ctrl #(
    .ROWS(4), .COLS(4), .DATA_WIDTH(8),
    .ACCU_DATA_WIDTH(16), .VEC_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_start(start), .i_num_vec(num_vec),
    .o_busy(busy), .o_done(done),
    .o_w_ren(w_ren), .o_w_addr(w_addr), .i_w_rdata(w_rdata),
    .o_a_ren(a_ren), .o_a_addr(a_addr), .i_a_rdata(a_rdata),
    .o_array_rst_n(arr_rst_n),
    .o_top_data(top_data), .o_top_valid(top_valid), .o_top_cmd(top_cmd),
    .o_left_data(left_data), .o_left_valid(left_valid),
    .o_left_cmd(left_cmd),
    .i_bot_data(bot_data), .i_bot_valid(bot_valid),
    .o_res_valid(res_valid), .o_res_addr(res_addr),
    .o_res_data(res_data)
  );

  always #5 clk = ~clk;

  // SRAM models, one-cycle read latency
  logic [31:0] wrow [4];
  logic [1:0]  cur_amode = '0;

  function automatic logic [31:0] avec(input logic [1:0] m,
                                       input logic [15:0] k);
    logic [7:0] b;
    b = 8'(k * 4);
    case (m)
      2'd0:    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
      2'd1:    return (k == 0) ? 32'h0000_0605 : 32'h0;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (w_ren) w_rdata <= wrow[w_addr];
    if (a_ren) a_rdata <= avec(cur_amode, a_addr);
  end

  // Weight-stationary PE grid: first cmd beat sticks, later beats pass down
  logic [7:0]  pw [4][4];
  logic        pl [4][4];
  logic        pv [4][4];
  logic [15:0] pd [4][4];
  logic [7:0]  ac [4][4];
  logic        av [4][4];
  logic [15:0] ps [4][4];

  always @(posedge clk) begin
    logic        tv, avin;
    logic [15:0] td, pin;
    logic [7:0]  ain;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!arr_rst_n) begin
          pl[r][c] <= 1'b0;
          pv[r][c] <= 1'b0;
          av[r][c] <= 1'b0;
          ps[r][c] <= '0;
        end else begin
          if (r == 0) begin
            tv  = top_valid[c] & top_cmd[c];
            td  = top_data[c*16 +: 16];
            pin = top_data[c*16 +: 16];
          end else begin
            tv  = pv[r-1][c];
            td  = pd[r-1][c];
            pin = ps[r-1][c];
          end
          if (c == 0) begin
            ain  = left_data[r*8 +: 8];
            avin = left_valid[r] & left_cmd[r];
          end else begin
            ain  = ac[r][c-1];
            avin = av[r][c-1];
          end
          if (tv && !pl[r][c]) begin
            pw[r][c] <= td[7:0];
            pl[r][c] <= 1'b1;
            pv[r][c] <= 1'b0;
          end else begin
            pv[r][c] <= tv;
            pd[r][c] <= td;
          end
          ac[r][c] <= ain;
          av[r][c] <= avin;
          ps[r][c] <= pin + 16'(pw[r][c]) * 16'(ain);
        end
      end
    end
  end

  always_comb begin
    bot_data  = '0;
    bot_valid = force_v;
    for (int c = 0; c < 4; c++) begin
      bot_data[c*16 +: 16] = ps[3][c];
      bot_valid[c] = bot_valid[c] | av[3][c];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, longint'({busy, done, w_ren, a_ren, res_valid,
        left_valid, left_cmd, top_valid, top_cmd}), 0);
    chk({tag, "_dat"}, longint'(|{w_addr, a_addr, left_data, top_data,
        res_addr, res_data}), 0);
  endtask

  // opt[0]: lone bottom valid injected; opt[1]: start pulsed while busy
  typedef struct packed {
    logic [127:0] w;
    logic [1:0]   amode;
    logic [15:0]  n;
    logic [15:0]  emul;
    logic [63:0]  efix;
    logic [1:0]   opt;
  } job_t;

  job_t tbl [6];

  task automatic run_job(input int i);
    job_t v;
    int cyc, nw, clr, wr, lv, bz, lat, n;
    logic got_done;
    logic [15:0] ev;
    v = tbl[i];
    n = int'(v.n);
    for (int r = 0; r < 4; r++) wrow[r] = v.w[r*32 +: 32];
    cur_amode = v.amode;
    lat = (n == 0) ? 11 : 20 + n;
    @(negedge clk);
    start = 1'b1;
    num_vec = v.n;
    cyc = 1; nw = 0; clr = 0; wr = 0; lv = 0;
    got_done = 1'b0;
    while (!got_done && cyc < lat + 20) begin
      @(negedge clk);
      start = 1'b0;
      force_v = '0;
      cyc++;
      if (!arr_rst_n) clr++;
      if (w_ren) wr++;
      if (left_valid[0]) begin
        lv++;
        if (v.opt[0] && lv == 1) force_v = 4'b1000;
        if (v.opt[1] && lv == 2) begin
          start = 1'b1;
          num_vec = 16'd3;
        end
      end
      if (res_valid) begin
        chk($sformatf("job%0d_w%0d_addr", i, nw), res_addr, nw);
        chk($sformatf("job%0d_w%0d_cycle", i, nw), cyc, lat - n + nw);
        for (int c = 0; c < 4; c++) begin
          ev = 16'(v.efix[c*16 +: 16] + v.emul * (nw * 4 + c));
          chk($sformatf("job%0d_w%0d_lane%0d", i, nw, c),
              res_data[c*16 +: 16], ev);
        end
        nw++;
      end
      if (done) got_done = 1'b1;
    end
    chk($sformatf("job%0d_done_seen", i), got_done, 1);
    chk($sformatf("job%0d_latency", i), cyc, lat);
    chk($sformatf("job%0d_writes", i), nw, n);
    chk($sformatf("job%0d_clear_cycles", i), clr, 1);
    chk($sformatf("job%0d_wren_cycles", i), wr, 4);
    chk($sformatf("job%0d_left_beats", i), lv, n);
    bz = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || res_valid || done) bz++;
    end
    chk($sformatf("job%0d_idle_after", i), bz, 0);
  endtask

  task automatic reset_mid_feed();
    int t, bz;
    for (int r = 0; r < 4; r++) wrow[r] = tbl[1].w[r*32 +: 32];
    cur_amode = 2'd0;
    @(negedge clk);
    start = 1'b1;
    num_vec = 16'd8;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!left_valid[0] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("rst_feed_reached", left_valid[0], 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_low");
    chk("rst_low_arr_rst", arr_rst_n, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_arr_rst", arr_rst_n, 1);
    chk("rst_rel_busy", busy, 0);
    bz = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || res_valid || busy) bz++;
    end
    chk("rst_no_done", bz, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{w: 128'h00000000_00000000_00000403_00000201, amode: 2'd1,
               n: 16'd1, emul: 16'd0, efix: 64'h0000_0000_0022_0017,
               opt: 2'd0};
    tbl[1] = '{w: 128'h01000000_00010000_00000100_00000001, amode: 2'd0,
               n: 16'd8, emul: 16'd1, efix: 64'h0, opt: 2'd1};
    tbl[2] = '{w: 128'h02000000_00020000_00000200_00000002, amode: 2'd0,
               n: 16'd8, emul: 16'd2, efix: 64'h0, opt: 2'd0};
    tbl[3] = '{w: 128'h01000000_00010000_00000100_00000001, amode: 2'd0,
               n: 16'd0, emul: 16'd1, efix: 64'h0, opt: 2'd0};
    tbl[4] = '{w: {16{8'hFF}}, amode: 2'd2, n: 16'd3, emul: 16'd0,
               efix: 64'hF804_F804_F804_F804, opt: 2'd0};
    tbl[5] = '{w: 128'h01000000_00010000_00000100_00000001, amode: 2'd0,
               n: 16'd8, emul: 16'd1, efix: 64'h0, opt: 2'd2};

    @(negedge clk);
    chk_zero("por");
    chk("por_arr_rst", arr_rst_n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_rst");
    chk("post_rst_arr_rst", arr_rst_n, 1);

    for (int i = 0; i < 6; i++) run_job(i);
    reset_mid_feed();
    run_job(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
